// File: rtl/rng_pkg.sv
// Shared definitions for the RNG-side blocks: FSM state type and default datapath width.
// Pure declarations; no logic, no latency.
// No flow control of its own.
package rng_pkg;

    localparam int RNG_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ITER
    } rng_mod_state_t;

endpackage

// File: rtl/rng_div_step.sv
// One restoring shift-subtract division step (combinational).
// Latency: 0 cycles.
// Backpressure: none, pure function of its inputs.
module rng_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // The shifted remainder needs WIDTH+1 bits for the compare, but any value
    // kept afterwards is below the divisor and therefore fits in WIDTH bits.
    always_comb begin
        r_sh   = {r, q[WIDTH-1]};
        ge     = (r_sh >= {1'b0, divisor});
        diff   = r_sh[WIDTH-1:0] - divisor;
        r_next = ge ? diff : r_sh[WIDTH-1:0];
        q_next = {q[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/rng_modulo_unit.sv
// Unsigned divider giving remainder/quotient for neighbour selection (optional RNG_MOD_EARLY_EXIT_EN).
// Latency: WIDTH+1 cycles from accepted start; 1 cycle for divisor 0 (and dividend <= divisor with early exit).
// Backpressure: start is only taken in IDLE; requests while busy are dropped, not queued.
module rng_modulo_unit
    import rng_pkg::*;
#(
    parameter int WIDTH = RNG_W,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             nrst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rng_remainder,
    output logic [WIDTH-1:0] rng_quotient,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

    rng_mod_state_t   state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    rng_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r       (r_q),
        .q       (q_q),
        .divisor (dvs_q),
        .r_next  (r_next),
        .q_next  (q_next)
    );

    always_ff @(posedge clock) begin
        if (!nrst) begin
            state_q <= IDLE;
            q_q     <= '0;
            dvs_q   <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        busy_d  = busy_q;
        done_d  = done_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                // q_q doubles as the dividend copy and the quotient shift register.
                if (start) begin
                    q_d     = dividend;
                    dvs_d   = divisor;
                    done_d  = 1'b0;
                    dbz_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (dvs_q == '0) begin
                    rem_d   = q_q;
                    quo_d   = '1;
                    dbz_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
`ifdef RNG_MOD_EARLY_EXIT_EN
                else if (q_q < dvs_q) begin
                    rem_d   = q_q;
                    quo_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (q_q == dvs_q) begin
                    rem_d   = '0;
                    quo_d   = WIDTH'(1);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
`endif
                else begin
                    r_d     = '0;
                    cnt_d   = CNT_INIT;
                    state_d = ITER;
                end
            end
            ITER: begin
                r_d = r_next;
                q_d = q_next;
                if (cnt_q == '0) begin
                    rem_d   = r_next;
                    quo_d   = q_next;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rng_remainder = rem_q;
    assign rng_quotient  = quo_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign div_by_zero   = dbz_q;

endmodule

// File: tb/tb_rng_modulo_unit.sv
// Bench for rng_modulo_unit: directed table and corner sequences at WIDTH=16,
// plus randomized operands at WIDTH=8 and WIDTH=16 against a plain-arithmetic model.
module tb_rng_modulo_unit;

`ifdef RNG_MOD_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif
    localparam int EE_LAT16 = EE ? 1 : 17;

    logic        clk;
    logic        nrst;
    logic        start_in [2];
    logic [31:0] a_in     [2];
    logic [31:0] b_in     [2];

    logic [15:0] rem16, quo16;
    logic [7:0]  rem8, quo8;
    logic        busy16, done16, dbz16;
    logic        busy8, done8, dbz8;

    logic [31:0] rem_v  [2];
    logic [31:0] quo_v  [2];
    logic        busy_v [2];
    logic        done_v [2];
    logic        dbz_v  [2];

    int nerr = 0;
    int nchk = 0;

    rng_modulo_unit #(.WIDTH(16)) dut16 (
        .clock         (clk),
        .nrst          (nrst),
        .start         (start_in[0]),
        .dividend      (a_in[0][15:0]),
        .divisor       (b_in[0][15:0]),
        .rng_remainder (rem16),
        .rng_quotient  (quo16),
        .busy          (busy16),
        .done          (done16),
        .div_by_zero   (dbz16)
    );

    rng_modulo_unit #(.WIDTH(8)) dut8 (
        .clock         (clk),
        .nrst          (nrst),
        .start         (start_in[1]),
        .dividend      (a_in[1][7:0]),
        .divisor       (b_in[1][7:0]),
        .rng_remainder (rem8),
        .rng_quotient  (quo8),
        .busy          (busy8),
        .done          (done8),
        .div_by_zero   (dbz8)
    );

    assign rem_v[0]  = {16'b0, rem16};
    assign quo_v[0]  = {16'b0, quo16};
    assign rem_v[1]  = {24'b0, rem8};
    assign quo_v[1]  = {24'b0, quo8};
    assign busy_v[0] = busy16;
    assign busy_v[1] = busy8;
    assign done_v[0] = done16;
    assign done_v[1] = done8;
    assign dbz_v[0]  = dbz16;
    assign dbz_v[1]  = dbz8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rem;
        logic [31:0] quo;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: unsigned division straight from the definition.
    function automatic void ref_div(input int w, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] rem, output logic [31:0] quo,
                                    output logic dbz, output int lat);
        logic [31:0] mask;
        mask = (w == 16) ? 32'hFFFF : 32'hFF;
        if (b == 0) begin
            rem = a;
            quo = mask;
            dbz = 1'b1;
            lat = 1;
        end else begin
            rem = a % b;
            quo = a / b;
            dbz = 1'b0;
            lat = (EE && a <= b) ? 1 : w + 1;
        end
    endfunction

    task automatic run_op(input int idx, input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_rem, input logic [31:0] exp_quo,
                          input logic exp_dbz, input int exp_lat, input int hold);
        int          w;
        int          n;
        logic [31:0] mask;
        logic [63:0] recon;
        w    = (idx == 0) ? 16 : 8;
        mask = (idx == 0) ? 32'hFFFF : 32'hFF;
        @(negedge clk);
        a_in[idx]     = a;
        b_in[idx]     = b;
        start_in[idx] = 1'b1;
        @(negedge clk);
        start_in[idx] = 1'b0;
        a_in[idx]     = $urandom & mask;
        b_in[idx]     = $urandom & mask;
        chk({tag, "_busy_start"}, 64'(busy_v[idx]), 64'd1);
        chk({tag, "_done_clr"}, 64'(done_v[idx]), 64'd0);
        n = 0;
        while (!done_v[idx] && n < w + 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_rem"}, 64'(rem_v[idx]), 64'(exp_rem));
        chk({tag, "_quo"}, 64'(quo_v[idx]), 64'(exp_quo));
        chk({tag, "_dbz"}, 64'(dbz_v[idx]), 64'(exp_dbz));
        chk({tag, "_busy_end"}, 64'(busy_v[idx]), 64'd0);
        if (b != 0) begin
            recon = 64'(quo_v[idx]) * 64'(b) + 64'(rem_v[idx]);
            chk({tag, "_inv"}, recon, 64'(a));
            chk({tag, "_rem_lt"}, 64'(rem_v[idx] < b), 64'd1);
        end
        repeat (hold) @(negedge clk);
        chk({tag, "_done_held"}, 64'(done_v[idx]), 64'd1);
        chk({tag, "_rem_held"}, 64'(rem_v[idx]), 64'(exp_rem));
    endtask

    task automatic run_random(input int idx, input int count);
        logic [31:0] mask, a, b, er, eq;
        logic        ed;
        int          el;
        int          w;
        w    = (idx == 0) ? 16 : 8;
        mask = (idx == 0) ? 32'hFFFF : 32'hFF;
        for (int i = 0; i < count; i++) begin
            case ($urandom_range(0, 9))
                0:       b = 0;
                1, 2, 3: b = $urandom_range(1, 12);
                default: b = $urandom & mask;
            endcase
            a = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 12)) : ($urandom & mask);
            ref_div(w, a, b, er, eq, ed, el);
            run_op(idx, (idx == 0) ? "rnd16" : "rnd8", a, b, er, eq, ed, el, $urandom_range(0, 2));
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{"d37_5",      32'd37,     32'd5,      32'd2,      32'd7,      1'b0, 17};
        vecs[1] = '{"dbz_1234",   32'h1234,   32'h0,      32'h1234,   32'hFFFF,   1'b1, 1};
        vecs[2] = '{"ffff_1",     32'hFFFF,   32'h1,      32'h0,      32'hFFFF,   1'b0, 17};
        vecs[3] = '{"ffff_ffff",  32'hFFFF,   32'hFFFF,   32'h0,      32'h1,      1'b0, EE_LAT16};
        vecs[4] = '{"d3_10",      32'd3,      32'd10,     32'd3,      32'd0,      1'b0, EE_LAT16};
        vecs[5] = '{"d100_7",     32'd100,    32'd7,      32'd2,      32'd14,     1'b0, 17};
        vecs[6] = '{"d0_5",       32'd0,      32'd5,      32'd0,      32'd0,      1'b0, EE_LAT16};
        vecs[7] = '{"ffff_fffe",  32'hFFFF,   32'hFFFE,   32'h1,      32'h1,      1'b0, 17};

        nrst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_in[i] = 1'b0;
            a_in[i]     = 32'd0;
            b_in[i]     = 32'd0;
        end
        repeat (3) @(negedge clk);
        chk("rst_rem", 64'(rem16), 64'd0);
        chk("rst_quo", 64'(quo16), 64'd0);
        chk("rst_busy", 64'(busy16), 64'd0);
        chk("rst_done", 64'(done16), 64'd0);
        chk("rst_dbz", 64'(dbz16), 64'd0);
        chk("rst_done8", 64'(done8), 64'd0);
        nrst = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op(0, vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].rem, vecs[i].quo,
                   vecs[i].dbz, vecs[i].lat, 1);

        // start pulsed mid-operation with other operands must be dropped
        @(negedge clk);
        a_in[0] = 32'd37; b_in[0] = 32'd5; start_in[0] = 1'b1;
        @(negedge clk);
        start_in[0] = 1'b0;
        n = 0;
        while (!done16 && n < 40) begin
            @(negedge clk);
            n++;
            start_in[0] = (n == 5);
            if (n == 5) begin
                a_in[0] = 32'd200;
                b_in[0] = 32'd3;
            end
        end
        start_in[0] = 1'b0;
        chk("ign_lat", 64'(n), 64'd17);
        chk("ign_rem", 64'(rem16), 64'd2);
        chk("ign_quo", 64'(quo16), 64'd7);

        // start held high: next op accepted in the IDLE cycle after done
        @(negedge clk);
        a_in[0] = 32'd37; b_in[0] = 32'd5; start_in[0] = 1'b1;
        @(negedge clk);
        n = 0;
        while (!done16 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("hold_lat1", 64'(n), 64'd17);
        chk("hold_rem1", 64'(rem16), 64'd2);
        a_in[0] = 32'd100; b_in[0] = 32'd7;
        @(negedge clk);
        start_in[0] = 1'b0;
        chk("hold_done_clr", 64'(done16), 64'd0);
        chk("hold_busy", 64'(busy16), 64'd1);
        n = 0;
        while (!done16 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("hold_lat2", 64'(n), 64'd17);
        chk("hold_rem2", 64'(rem16), 64'd2);
        chk("hold_quo2", 64'(quo16), 64'd14);

        // reset in the middle of the iterations
        @(negedge clk);
        a_in[0] = 32'd1000; b_in[0] = 32'd3; start_in[0] = 1'b1;
        @(negedge clk);
        start_in[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy_pre", 64'(busy16), 64'd1);
        nrst = 1'b0;
        @(negedge clk);
        chk("mid_rst_rem", 64'(rem16), 64'd0);
        chk("mid_rst_quo", 64'(quo16), 64'd0);
        chk("mid_rst_busy", 64'(busy16), 64'd0);
        chk("mid_rst_done", 64'(done16), 64'd0);
        chk("mid_rst_dbz", 64'(dbz16), 64'd0);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_no_done", 64'(done16), 64'd0);
        run_op(0, "post_rst", 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 17, 1);

        fork
            run_random(0, 2000);
            run_random(1, 2000);
        join

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
